// File: rtl/v810_bus_pkg.sv
// Shared types and constants for V810 external-bus targets.
// Holds the target FSM state encoding, bus status codes and the wait-state counter width.
package v810_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2,
        RDY  = 2'd3
    } ebi_state_t;

    // Bus status (ST[1:0]) as driven by the CPU during a cycle
    localparam logic [1:0] BST_IACK  = 2'b00;
    localparam logic [1:0] BST_HALT  = 2'b01;
    localparam logic [1:0] BST_DATA  = 2'b10;
    localparam logic [1:0] BST_INSTR = 2'b11;

    localparam int WS_CW = 4;

endpackage

// File: rtl/v810_ebi_target_if.sv
// CPU-side pins of the V810 external bus as seen by one target.
// master = CPU/bus side, slave = responding target.
interface v810_ebi_target_if;
    logic        SEL;
    logic [31:0] A;
    logic [31:0] D_O;
    logic [31:0] D_I;
    logic [3:0]  BEn;
    logic [1:0]  ST;
    logic        DAn;
    logic        MRQn;
    logic        RW;
    logic        BCYSTn;
    logic        READYn;
    logic        SZRQn;

    modport master (
        output SEL, A, D_O, BEn, ST, DAn, MRQn, RW, BCYSTn,
        input  D_I, READYn, SZRQn
    );

    modport slave (
        input  SEL, A, D_O, BEn, ST, DAn, MRQn, RW, BCYSTn,
        output D_I, READYn, SZRQn
    );
endinterface

// File: rtl/v810_ebi_lane_map.sv
// Combinational byte-lane steering between the CPU data bus and a 32-bit memory word.
// No latency, no backpressure; in 16-bit mode the halfword is picked by address bit 1.
module v810_ebi_lane_map #(
    parameter int DW = 32
) (
    input  logic        a1,
    input  logic [3:0]  ben,
    input  logic [31:0] cpu_wdat,
    input  logic [31:0] mem_rdat,
    output logic [3:0]  mem_nbe,
    output logic [31:0] mem_wdat,
    output logic [31:0] cpu_rdat
);

    always_comb begin
        mem_nbe  = ben;
        mem_wdat = cpu_wdat;
        cpu_rdat = mem_rdat;
        if (DW == 16) begin
            // 16-bit CPU only drives D[15:0]; replicate so either half of the word can take it
            mem_nbe  = a1 ? {ben[1:0], 2'b11} : {2'b11, ben[1:0]};
            mem_wdat = {cpu_wdat[15:0], cpu_wdat[15:0]};
            cpu_rdat = {16'h0000, (a1 ? mem_rdat[31:16] : mem_rdat[15:0])};
        end
    end

endmodule

// File: rtl/v810_ebi_target.sv
// V810 bus slave driving a synchronous SRAM port; READYn after WS+2 CE cycles.
// Stalls wholesale on CE=0; the CPU aborts a pending cycle by releasing DAn before RDY.
module v810_ebi_target
    import v810_bus_pkg::*;
#(
    parameter int WS = 0,
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic                CLK,
    input  logic                RESn,
    input  logic                CE,
    v810_ebi_target_if.slave    bus,
    output logic [AW-1:0]       MEM_A,
    output logic                MEM_nCE,
    output logic                MEM_nWE,
    output logic [3:0]          MEM_nBE,
    output logic [31:0]         MEM_DI,
    input  logic [31:0]         MEM_DO
);

    localparam logic [WS_CW-1:0] WS_INIT = WS_CW'(WS);

    ebi_state_t       state, state_nxt;
    logic [WS_CW-1:0] cnt, cnt_nxt;
    logic             capture;

    logic [AW+1:1]    lat_a;
    logic [3:0]       lat_ben;
    logic             lat_rw;
    logic             lat_mrqn;
    logic [31:0]      lat_do;

    logic [3:0]       map_nbe;
    logic [31:0]      map_wdat;
    logic [31:0]      map_rdat;
    logic             mem_cyc;

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_a    <= '0;
            lat_ben  <= 4'hF;
            lat_rw   <= 1'b1;
            lat_mrqn <= 1'b1;
            lat_do   <= '0;
        end else if (CE) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                lat_a    <= bus.A[AW+1:1];
                lat_ben  <= bus.BEn;
                lat_rw   <= bus.RW;
                lat_mrqn <= bus.MRQn;
                lat_do   <= bus.D_O;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.DAn && bus.SEL) begin
                    capture   = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                cnt_nxt = WS_INIT;
                if (bus.DAn)
                    state_nxt = IDLE;
                else
                    state_nxt = (WS > 0) ? WAIT : RDY;
            end
            WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (bus.DAn)
                    state_nxt = IDLE;
                else if (cnt <= 1)
                    state_nxt = RDY;
            end
            RDY: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    v810_ebi_lane_map #(.DW(DW)) u_lane_map (
        .a1       (lat_a[1]),
        .ben      (lat_ben),
        .cpu_wdat (lat_do),
        .mem_rdat (MEM_DO),
        .mem_nbe  (map_nbe),
        .mem_wdat (map_wdat),
        .cpu_rdat (map_rdat)
    );

    // Memory is strobed only in ACC; non-memory cycles (MRQn=1) keep the port idle
    assign mem_cyc = (state == ACC) && !lat_mrqn;

    assign MEM_A   = lat_a[AW+1:2];
    assign MEM_nCE = !mem_cyc;
    assign MEM_nWE = mem_cyc ? lat_rw : 1'b1;
    assign MEM_nBE = mem_cyc ? map_nbe : 4'hF;
    assign MEM_DI  = map_wdat;

    // MEM_DO is the RAM's registered output, held since the ACC strobe
    assign bus.D_I    = (state == RDY && lat_rw && !lat_mrqn) ? map_rdat : 32'h0;
    assign bus.READYn = (state != RDY);
    assign bus.SZRQn  = !((state == RDY) && (DW == 16));

    logic unused_ok;
    assign unused_ok = ^{bus.A[31:AW+2], bus.A[0], bus.ST, bus.BCYSTn};

endmodule

// File: tb/tb_v810_ebi_target.sv
// Directed bench: three targets (32b/WS0, 32b/WS2, 16b/WS1) each with a behavioural sync RAM.
module tb_v810_ebi_target;
    import v810_bus_pkg::*;

    logic clk = 1'b0;
    logic rstn, ce;
    always #5 clk = ~clk;

    logic [2:0]  sel;
    logic [31:0] a, d_o;
    logic [3:0]  ben;
    logic [1:0]  st;
    logic        dan, mrqn, rw, bcystn;

    v810_ebi_target_if bi[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_bus
        assign bi[g].SEL    = sel[g];
        assign bi[g].A      = a;
        assign bi[g].D_O    = d_o;
        assign bi[g].BEn    = ben;
        assign bi[g].ST     = st;
        assign bi[g].DAn    = dan;
        assign bi[g].MRQn   = mrqn;
        assign bi[g].RW     = rw;
        assign bi[g].BCYSTn = bcystn;
    end

    logic [9:0]  m_a   [3];
    logic        m_nce [3];
    logic        m_nwe [3];
    logic [3:0]  m_nbe [3];
    logic [31:0] m_di  [3];
    logic [31:0] m_do  [3];
    logic [31:0] mem   [3][1024];

    logic        ld_en;
    int          ld_k;
    logic [9:0]  ld_a;
    logic [31:0] ld_d;

    always @(posedge clk) begin
        if (ld_en) mem[ld_k][ld_a] <= ld_d;
        for (int k = 0; k < 3; k++) begin
            if (!m_nce[k]) begin
                if (!m_nwe[k])
                    for (int b = 0; b < 4; b++)
                        if (!m_nbe[k][b]) mem[k][m_a[k]][8*b +: 8] <= m_di[k][8*b +: 8];
                m_do[k] <= mem[k][m_a[k]];
            end
        end
    end

    v810_ebi_target #(.WS(0), .DW(32), .AW(10)) d0 (
        .CLK(clk), .RESn(rstn), .CE(ce), .bus(bi[0]),
        .MEM_A(m_a[0]), .MEM_nCE(m_nce[0]), .MEM_nWE(m_nwe[0]),
        .MEM_nBE(m_nbe[0]), .MEM_DI(m_di[0]), .MEM_DO(m_do[0]));

    v810_ebi_target #(.WS(2), .DW(32), .AW(10)) d1 (
        .CLK(clk), .RESn(rstn), .CE(ce), .bus(bi[1]),
        .MEM_A(m_a[1]), .MEM_nCE(m_nce[1]), .MEM_nWE(m_nwe[1]),
        .MEM_nBE(m_nbe[1]), .MEM_DI(m_di[1]), .MEM_DO(m_do[1]));

    v810_ebi_target #(.WS(1), .DW(16), .AW(10)) d2 (
        .CLK(clk), .RESn(rstn), .CE(ce), .bus(bi[2]),
        .MEM_A(m_a[2]), .MEM_nCE(m_nce[2]), .MEM_nWE(m_nwe[2]),
        .MEM_nBE(m_nbe[2]), .MEM_DI(m_di[2]), .MEM_DO(m_do[2]));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_load(input int k, input logic [9:0] wa, input logic [31:0] wd);
        ld_en = 1'b1; ld_k = k; ld_a = wa; ld_d = wd;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic cyc_start(input int k, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, input logic r, input logic mq, input logic [1:0] s);
        sel = 3'b000; sel[k] = 1'b1;
        a = addr; d_o = wd; ben = be; rw = r; mrqn = mq; st = s;
        dan = 1'b0; bcystn = 1'b0;
    endtask

    task automatic cyc_end();
        dan = 1'b1; sel = 3'b000; bcystn = 1'b1; mrqn = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; ce = 1'b1; sel = 3'b000; a = '0; d_o = '0; ben = 4'hF;
        st = BST_DATA; dan = 1'b1; mrqn = 1'b0; rw = 1'b1; bcystn = 1'b1;
        ld_en = 1'b0; ld_k = 0; ld_a = '0; ld_d = '0;

        mem_load(0, 10'd1, 32'h1234_5678);
        mem_load(1, 10'd2, 32'h1111_1111);
        mem_load(2, 10'd1, 32'hAAAA_5555);
        mem_load(2, 10'd0, 32'h0000_0000);
        tick();

        // reset state
        check("rst_readyn",  {31'h0, bi[0].READYn}, 32'h1);
        check("rst_szrqn16", {31'h0, bi[2].SZRQn},  32'h1);
        check("rst_mem_ctl", {25'h0, m_nce[0], m_nwe[0], m_nbe[0], bi[0].SZRQn}, 32'h7F);
        check("rst_mem_a",   {22'h0, m_a[0]}, 32'h0);
        check("rst_mem_di",  m_di[0], 32'h0);
        check("rst_d_i",     bi[0].D_I, 32'h0);
        rstn = 1'b1;
        tick();

        // DW=32 WS=0 read of word 1
        cyc_start(0, 32'h0000_0004, 32'h0, 4'h0, 1'b1, 1'b0, BST_DATA);
        tick();
        check("r32_nce",    {31'h0, m_nce[0]}, 32'h0);
        check("r32_nwe",    {31'h0, m_nwe[0]}, 32'h1);
        check("r32_mem_a",  {22'h0, m_a[0]}, 32'h1);
        check("r32_rdy_n1", {31'h0, bi[0].READYn}, 32'h1);
        tick();
        check("r32_readyn", {31'h0, bi[0].READYn}, 32'h0);
        check("r32_d_i",    bi[0].D_I, 32'h1234_5678);
        check("r32_szrqn",  {31'h0, bi[0].SZRQn}, 32'h1);
        cyc_end();
        tick();
        check("r32_idle",   {30'h0, bi[0].READYn, m_nce[0]}, 32'h3);
        tick();

        // DW=32 WS=2 write, low halfword enabled
        cyc_start(1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1100, 1'b0, 1'b0, BST_DATA);
        tick();
        check("w32_nwe",   {31'h0, m_nwe[1]}, 32'h0);
        check("w32_nbe",   {28'h0, m_nbe[1]}, 32'hC);
        check("w32_di",    m_di[1], 32'hDEAD_BEEF);
        tick();
        check("w32_wait1", {30'h0, bi[1].READYn, m_nce[1]}, 32'h3);
        tick();
        check("w32_wait2", {31'h0, bi[1].READYn}, 32'h1);
        tick();
        check("w32_readyn", {31'h0, bi[1].READYn}, 32'h0);
        check("w32_d_i",    bi[1].D_I, 32'h0);
        cyc_end();
        tick();
        check("w32_done",  {31'h0, bi[1].READYn}, 32'h1);
        check("w32_word2", mem[1][2], 32'h1111_BEEF);
        tick();

        // DW=16 WS=1 read of upper halfword
        cyc_start(2, 32'h0000_0006, 32'h0, 4'b1100, 1'b1, 1'b0, BST_DATA);
        tick();
        check("r16_nbe",   {27'h0, m_nce[2], m_nbe[2]}, 32'h03);
        tick();
        check("r16_wait",  {30'h0, bi[2].READYn, bi[2].SZRQn}, 32'h3);
        tick();
        check("r16_rdy",   {30'h0, bi[2].READYn, bi[2].SZRQn}, 32'h0);
        check("r16_d_i",   bi[2].D_I, 32'h0000_AAAA);
        cyc_end();
        tick();
        tick();

        // DW=16 WS=1 write of byte 2 via upper halfword
        cyc_start(2, 32'h0000_0002, 32'h0000_C3D4, 4'b1110, 1'b0, 1'b0, BST_DATA);
        tick();
        check("w16_nbe",   {27'h0, m_nwe[2], m_nbe[2]}, 32'h0B);
        check("w16_di",    m_di[2], 32'hC3D4_C3D4);
        tick();
        tick();
        check("w16_rdy",   {30'h0, bi[2].READYn, bi[2].SZRQn}, 32'h0);
        cyc_end();
        tick();
        check("w16_word0", mem[2][0], 32'h00D4_0000);
        tick();

        // halt acknowledge: non-memory cycle
        cyc_start(0, 32'h0000_0000, 32'h0, 4'h0, 1'b1, 1'b1, BST_HALT);
        tick();
        check("halt_acc_nce", {30'h0, bi[0].READYn, m_nce[0]}, 32'h3);
        tick();
        check("halt_readyn", {30'h0, bi[0].READYn, m_nce[0]}, 32'h1);
        check("halt_d_i",    bi[0].D_I, 32'h0);
        cyc_end();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_idle", {25'h0, bi[0].READYn, m_nce[0], m_nwe[0], m_nbe[0]}, 32'h7F);
        end

        // synchronous reset during WAIT with CE low
        cyc_start(1, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b0, BST_DATA);
        tick();
        check("rstw_mem_a", {22'h0, m_a[1]}, 32'h4);
        tick();
        ce = 1'b0; rstn = 1'b0;
        tick();
        check("rstw_state", 32'(d1.state), 32'(IDLE));
        check("rstw_ctl",   {25'h0, bi[1].READYn, m_nce[1], m_nwe[1], m_nbe[1]}, 32'h7F);
        check("rstw_mem_a", {22'h0, m_a[1]}, 32'h0);
        check("rstw_di_di", m_di[1] | bi[1].D_I, 32'h0);
        rstn = 1'b1; ce = 1'b1;
        cyc_end();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstw_no_rdy", {31'h0, bi[1].READYn}, 32'h1);
        end

        // abort: DAn released during WAIT
        cyc_start(1, 32'h0000_0008, 32'h0, 4'h0, 1'b1, 1'b0, BST_DATA);
        tick();
        tick();
        dan = 1'b1;
        tick();
        check("abort_state", 32'(d1.state), 32'(IDLE));
        sel = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_rdy", {31'h0, bi[1].READYn}, 32'h1);
        end

        // CE stall during DW=16 WS=1 read of lower halfword
        cyc_start(2, 32'h0000_0004, 32'h0, 4'b1100, 1'b1, 1'b0, BST_DATA);
        tick();
        ce = 1'b0;
        tick();
        check("ce_hold_acc", 32'(d2.state), 32'(ACC));
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tick();
        check("ce_hold_wait", {31'h0, bi[2].READYn}, 32'h1);
        ce = 1'b1;
        tick();
        check("ce_rdy",     {30'h0, bi[2].READYn, bi[2].SZRQn}, 32'h0);
        check("ce_d_i",     bi[2].D_I, 32'h0000_5555);
        ce = 1'b0;
        tick();
        check("ce_rdy_frz", {31'h0, bi[2].READYn}, 32'h0);
        ce = 1'b1;
        cyc_end();
        tick();
        check("ce_rdy_once", {30'h0, bi[2].READYn, bi[2].SZRQn}, 32'h3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
